// File: rtl/alu_ctl_unit.sv
// ALU control unit: combinational opcode decode plus a registered scalar/4x8-bit lane ALU.
// Latency: decode is combinational; result/zero/valid_out appear 1 cycle after en. No backpressure; en=0 or flush clears the output.
// ALU_VECTOR_EN: when defined, v selects the lane ALUs; when undefined, v is ignored and only the scalar path exists.
module alu_ctl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [4:0]  opcode,
    input  logic        v,
    input  logic        i,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [7:0]  imm8,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        jump,
    output logic [1:0]  aluop,
    output logic [31:0] result,
    output logic        zero,
    output logic        valid_out
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_ORR = 5'b00011;
    localparam logic [4:0] OP_LDR = 5'b00100;
    localparam logic [4:0] OP_STR = 5'b00101;
    localparam logic [4:0] OP_B   = 5'b00110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    logic [6:0]  dec_dat;
    logic [31:0] b_eff;
    logic [31:0] scalar_res;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        valid_d, valid_q;

    // Packed as {memread, memwrite, memtoreg, regwrite, jump, aluop[1:0]}
    always_comb begin
        dec_dat = 7'b0000000;
        case (opcode)
            OP_ADD:  dec_dat = 7'b0001000;
            OP_SUB:  dec_dat = 7'b0001001;
            OP_AND:  dec_dat = 7'b0001010;
            OP_ORR:  dec_dat = 7'b0001011;
            OP_LDR:  dec_dat = 7'b1011000;
            OP_STR:  dec_dat = 7'b0100000;
            OP_B:    dec_dat = 7'b0000101;
            default: dec_dat = 7'b0000000;
        endcase
    end

    assign {memread, memwrite, memtoreg, regwrite, jump, aluop} = dec_dat;

    assign b_eff = i ? {4{imm8}} : b;

    always_comb begin
        scalar_res = 32'h0;
        case (aluop)
            ALU_ADD: scalar_res = a + b_eff;
            ALU_SUB: scalar_res = a - b_eff;
            ALU_AND: scalar_res = a & b_eff;
            ALU_ORR: scalar_res = a | b_eff;
            default: scalar_res = 32'h0;
        endcase
    end

`ifdef ALU_VECTOR_EN
    logic [31:0] vector_res;

    // Each lane wraps independently; no carry or borrow crosses a byte boundary
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] la, lb, lr;
        assign la = a[8*l +: 8];
        assign lb = b_eff[8*l +: 8];
        always_comb begin
            lr = 8'h0;
            case (aluop)
                ALU_ADD: lr = la + lb;
                ALU_SUB: lr = la - lb;
                ALU_AND: lr = la & lb;
                ALU_ORR: lr = la | lb;
                default: lr = 8'h0;
            endcase
        end
        assign vector_res[8*l +: 8] = lr;
    end

    assign result_d = v ? vector_res : scalar_res;
`else
    logic unused_v;
    assign unused_v = v;
    assign result_d = scalar_res;
`endif

    // zero tracks the scalar result even when the lane result is selected
    assign zero_d  = (scalar_res == 32'h0);
    assign valid_d = en & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'h0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (valid_d) begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= 1'b1;
        end else begin
            result_q <= 32'h0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_alu_ctl_unit.sv
// Directed-vector bench for alu_ctl_unit; expected values are hand-computed constants.
module tb_alu_ctl_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic [4:0]  opcode;
    logic        v;
    logic        i;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  imm8;
    logic        memread, memwrite, memtoreg, regwrite, jump;
    logic [1:0]  aluop;
    logic [31:0] result;
    logic        zero;
    logic        valid_out;

    int nvec;
    int nbad;

    alu_ctl_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .opcode    (opcode),
        .v         (v),
        .i         (i),
        .a         (a),
        .b         (b),
        .imm8      (imm8),
        .memread   (memread),
        .memwrite  (memwrite),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .jump      (jump),
        .aluop     (aluop),
        .result    (result),
        .zero      (zero),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic [4:0] op,
                         input logic vv, input logic ii, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [7:0] im);
        rst = r; en = e; flush = f; opcode = op; v = vv; i = ii; a = aa; b = bb; imm8 = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dec();
        return {25'h0, memread, memwrite, memtoreg, regwrite, jump, aluop};
    endfunction

    function automatic logic [31:0] outs();
        return {result[31:2], 2'b00} ^ {30'h0, zero, valid_out};
    endfunction

    initial begin
        logic [31:0] exp_vadd;
        logic [31:0] exp_vsub;
        logic [4:0]  ops [9];
        logic [6:0]  dexp [9];
        nvec = 0;
        nbad = 0;

`ifdef ALU_VECTOR_EN
        exp_vadd = 32'h00000000;
        exp_vsub = 32'h000001FF;
`else
        exp_vadd = 32'h00000100;
        exp_vsub = 32'h000000FF;
`endif

        // Reset with a live operation presented: outputs stay cleared, decode still live
        drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h000000FF, 32'h1, 8'h0);
        tick();
        tick();
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'h0, zero}, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_decode_add", dec(), 32'h08);

        // Scalar ADD
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h000000FF, 32'h1, 8'h0);
        tick();
        chk("add_s_result", result, 32'h00000100);
        chk("add_s_zero", {31'h0, zero}, 32'h0);
        chk("add_s_valid", {31'h0, valid_out}, 32'h1);

        // Vector ADD: lane 0 wraps to 0, no carry into lane 1; zero follows scalar
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 32'h000000FF, 32'h1, 8'h0);
        tick();
        chk("add_v_result", result, exp_vadd);
        chk("add_v_zero", {31'h0, zero}, 32'h0);

        // SUB equal operands
        drive(1'b0, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 8'h0);
        #1;
        chk("sub_decode", dec(), 32'h09);
        tick();
        chk("sub_result", result, 32'h0);
        chk("sub_zero", {31'h0, zero}, 32'h1);
        chk("sub_valid", {31'h0, valid_out}, 32'h1);

        // Branch with same operands: jump decoded, zero from SUB
        drive(1'b0, 1'b1, 1'b0, 5'b00110, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 8'h0);
        #1;
        chk("b_jump", {31'h0, jump}, 32'h1);
        tick();
        chk("b_zero", {31'h0, zero}, 32'h1);

        // Immediate AND, vector mode
        drive(1'b0, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 8'h0F);
        tick();
        chk("andi_v_result", result, 32'h0F0F0F0F);
        chk("andi_v_zero", {31'h0, zero}, 32'h0);

        // Vector SUB borrow stays inside lane 0
        drive(1'b0, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, 32'h00000100, 32'h1, 8'h0);
        tick();
        chk("sub_v_result", result, exp_vsub);
        chk("sub_v_zero", {31'h0, zero}, 32'h0);

        // ORR with register operand, immediate ignored
        drive(1'b0, 1'b1, 1'b0, 5'b00011, 1'b0, 1'b0, 32'hF0000000, 32'h0000000F, 8'hAA);
        tick();
        chk("orr_result", result, 32'hF000000F);

        // Scalar ADD wraps modulo 2^32
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 8'h0);
        tick();
        chk("add_wrap_result", result, 32'h0);
        chk("add_wrap_zero", {31'h0, zero}, 32'h1);

        // Decode sweep, en low so nothing is captured
        ops  = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                 5'b00101, 5'b00110, 5'b00111, 5'b11111};
        dexp = '{7'b0001000, 7'b0001001, 7'b0001010, 7'b0001011, 7'b1011000,
                 7'b0100000, 7'b0000101, 7'b0000000, 7'b0000000};
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b0, 1'b0, ops[k], 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
            #1;
            chk($sformatf("decode_op%05b", ops[k]), dec(), {25'h0, dexp[k]});
        end
        tick();
        chk("en_low_valid", {31'h0, valid_out}, 32'h0);
        chk("en_low_result", result, 32'h0);

        // Unknown opcode still runs the ALU as add
        drive(1'b0, 1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 32'h1, 32'h2, 8'h0);
        tick();
        chk("unk_result", result, 32'h3);

        // Reset mid-stream after a held result
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h000000FF, 32'h1, 8'h0);
        tick();
        chk("hold_result", result, 32'h00000100);
        drive(1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h000000FF, 32'h1, 8'h0);
        tick();
        chk("midrst_result", result, 32'h0);
        chk("midrst_valid", {31'h0, valid_out}, 32'h0);

        // First en after reset release
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h10, 32'h20, 8'h0);
        tick();
        chk("post_rst_result", result, 32'h30);
        chk("post_rst_valid", {31'h0, valid_out}, 32'h1);

        // Flush with en
        drive(1'b0, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, 32'h5, 32'h5, 8'h0);
        tick();
        chk("flush_valid", {31'h0, valid_out}, 32'h0);
        chk("flush_result", result, 32'h0);
        chk("flush_zero", {31'h0, zero}, 32'h0);

        // Reset and flush together after a valid op
        drive(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 32'h7, 32'h1, 8'h0);
        tick();
        chk("pre_rstflush_valid", {31'h0, valid_out}, 32'h1);
        drive(1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 32'h7, 32'h1, 8'h0);
        tick();
        chk("rstflush_outs", outs(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/alu_ctl_unit.md
ALU_CTL_UNIT -- requirements
Module: alu_ctl_unit

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  operand/opcode valid this cycle.
REQ-005 flush  input  1  discard the operation being captured this cycle.
REQ-006 opcode  input  5  instruction opcode.
REQ-007 v  input  1  vector (4x8-bit lane) mode select.
REQ-008 i  input  1  immediate select for operand B.
REQ-009 a  input  32  operand A.
REQ-010 b  input  32  register operand B.
REQ-011 imm8  input  8  8-bit immediate.
REQ-012 memread, memwrite, memtoreg, regwrite, jump  output  1 each  combinational decode of opcode.
REQ-013 aluop  output  2  combinational decode of opcode.
REQ-014 result  output  32  registered ALU result.
REQ-015 zero  output  1  registered zero flag.
REQ-016 valid_out  output  1  result/zero hold a valid operation.

Function
REQ-017 Decode SHALL be purely combinational, as {memread,memwrite,memtoreg,regwrite,jump,aluop}:
- 00000 ADD -> 0,0,0,1,0,00
- 00001 SUB -> 0,0,0,1,0,01
- 00010 AND -> 0,0,0,1,0,10
- 00011 ORR -> 0,0,0,1,0,11
- 00100 LDR -> 1,0,1,1,0,00
- 00101 STR -> 0,1,0,0,0,00
- 00110 B -> 0,0,0,0,1,01
- all other opcodes -> all zero.
REQ-018 Effective B SHALL be {imm8,imm8,imm8,imm8} when i=1, else b.
REQ-019 aluop SHALL select the operation: 00 add, 01 subtract (A-B), 10 bitwise AND, 11 bitwise OR.
REQ-020 Scalar path: 32-bit operation, modulo 2^32; carry and overflow are discarded.
REQ-021 Vector path: four independent 8-bit lanes ([7:0], [15:8], [23:16], [31:24]), each modulo 256, with no carry or borrow between lanes.
REQ-022 The result SHALL come from the vector path when v=1, else from the scalar path.
REQ-023 zero SHALL be 1 iff the scalar 32-bit result equals 0, regardless of v.
REQ-024 Latency is 1 cycle: on a rising edge with en=1 and flush=0, result, zero and valid_out=1 reflect the inputs sampled at that edge.
REQ-025 On a rising edge with en=0 or flush=1, result=0, zero=0 and valid_out=0.
REQ-026 Decode outputs SHALL not depend on en, flush or rst.
REQ-027 When rst and flush are asserted together, rst takes precedence; the resulting outputs are identical.

Reset
REQ-028 On a rising edge with rst=1: result=0x00000000, zero=0, valid_out=0.
REQ-029 Reset asserted mid-stream drops the in-flight operation; the first en after deassertion produces an output one cycle later.

Configuration
REQ-030 Macro ALU_VECTOR_EN defined: v selects the vector path as specified in REQ-022.
REQ-031 Macro ALU_VECTOR_EN undefined: v is ignored, the lane ALUs are not built, and the result always comes from the scalar path.

Verification
REQ-032 ADD scalar: a=0x000000FF, b=0x00000001, v=0, i=0 -> next cycle result=0x00000100, zero=0, valid_out=1.
REQ-033 ADD vector (ALU_VECTOR_EN defined): same operands with v=1 -> result=0x00000000, zero=0; same operands with ALU_VECTOR_EN undefined -> result=0x00000100.
REQ-034 SUB: a=b=0x12345678 -> result=0x00000000, zero=1; opcode B with the same operands -> jump=1, zero=1.
REQ-035 Immediate AND vector: a=0xFFFFFFFF, i=1, imm8=0x0F, v=1 -> result=0x0F0F0F0F, zero=0.
REQ-036 Decode sweep: opcode 00100 -> memread=1, memtoreg=1, regwrite=1, aluop=00; opcode 11111 -> all decode outputs 0.
REQ-037 Reset/flush: result=0x00000100 held, then rst=1 at the next edge -> result=0, valid_out=0; flush=1 with en=1 -> valid_out=0 at the next edge.
